// File: rtl/downcnt8_timer.sv
// Programmable down-counting interval timer: loads a period, counts to zero and
// pulses tc on terminal count, in one-shot or periodic auto-reload mode.
module downcnt8_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             tc
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] period_r;
  logic [WIDTH-1:0] period_s;
  logic [WIDTH-1:0] out_s;
  logic             tc_s;

  // Next-state and next-output decode, priority load > stop > start > counting.
  always_comb begin
    state_s  = state_r;
    period_s = period_r;
    out_s    = out;
    tc_s     = 1'b0;
    if (load) begin
      period_s = data;
      out_s    = data;
      if (start && (data != ZERO)) begin
        state_s = RUN;
      end else begin
        state_s = state_r;
      end
    end else if (stop) begin
      state_s = IDLE;
    end else if (state_r == IDLE) begin
      if (start && (out != ZERO)) begin
        state_s = RUN;
      end else if (start && (period_r != ZERO)) begin
        // Resuming from a finished count restarts the programmed period.
        out_s   = period_r;
        state_s = RUN;
      end else begin
        state_s = IDLE;
      end
    end else begin
      if (out > ONE) begin
        out_s = out - ONE;
      end else if (out == ONE) begin
        out_s   = ZERO;
        tc_s    = 1'b1;
        state_s = mode ? RUN : IDLE;
      end else if (mode && (period_r != ZERO)) begin
        out_s   = period_r;
        state_s = RUN;
      end else begin
        // Zero count with nothing to reload (one-shot, or period of zero).
        state_s = IDLE;
      end
    end
  end

  // State, period and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      period_r <= ZERO;
      out      <= ZERO;
      busy     <= 1'b0;
      tc       <= 1'b0;
    end else begin
      state_r  <= state_s;
      period_r <= period_s;
      out      <= out_s;
      busy     <= (state_s == RUN);
      tc       <= tc_s;
    end
  end

endmodule

// File: doc/downcnt8_timer.md
# downcnt8_timer

Programmable down-counting interval timer with an 8-bit default width. It counts in the opposite direction from the team's 8-bit loadable up-counter: it loads a period, counts down to zero, and flags the terminal count. It runs in one-shot or periodic (auto-reload) mode. It sits beside the up-counter in the timing/control path and produces time-outs and periodic ticks for downstream logic.

## Interface
Parameters:
- WIDTH, 8, counter and period width in bits

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous reset, active-high
- load  input  1  synchronous load: period_reg <= data and out <= data
- data  input  WIDTH  period value, sampled when load=1
- start  input  1  begin or resume counting
- stop  input  1  pause counting and hold out
- mode  input  1  0 = one-shot, 1 = periodic auto-reload; sampled every cycle
- out  output  WIDTH  current count, registered
- busy  output  1  high while in RUN, registered
- tc  output  1  terminal-count pulse, registered, high in the cycle out==0 is reached while counting

## Operation
- Internal state: period_reg[WIDTH-1:0], plus a 2-state FSM with states IDLE and RUN.
- Priority each cycle: rst > load > stop > start > counting.
- Reset: out=0, period_reg=0, state=IDLE, busy=0, tc=0.

Load:
- period_reg<=data and out<=data; tc<=0.
- If start=1 in the same cycle and data!=0, go to RUN; otherwise the state is unchanged.
- A load while in RUN restarts the count from data and stays in RUN. If data==0, the next cycle follows the out==0 rule below.

Stop:
- In RUN, go to IDLE with out held and tc<=0.
- In IDLE, no effect.
- If start and stop are both high, stop wins.

Start:
- In IDLE with out!=0: go to RUN, out unchanged.
- In IDLE with out==0 and period_reg!=0: out<=period_reg, go to RUN.
- In IDLE with out==0 and period_reg==0: ignored, stay IDLE.
- In RUN: ignored.

RUN, each cycle with no load/stop/rst:
- out>1: out<=out-1, tc<=0.
- out==1: out<=0, tc<=1. If mode=0, go to IDLE (busy<=0); if mode=1, stay in RUN.
- out==0 (periodic only): out<=period_reg, tc<=0. If period_reg==0, go to IDLE instead.

In IDLE, out holds and tc=0.
Arithmetic is unsigned modulo 2^WIDTH. There is no wrap below 0, because decrement only occurs when out>=2 or out==1.

## Timing
- start in cycle n: busy=1 from n+1, out unchanged at n+1, first decrement visible at n+2.
- One-shot after load P, start: out steps P, P-1, …, 1 with busy=1 (P cycles). The next cycle shows out=0, tc=1, busy=0.
- Periodic: the sequence P, …, 1, 0, P, … repeats. tc is high exactly one cycle per P+1 cycles, aligned with out==0.
- tc is never high for two consecutive cycles when period_reg>=1.
- stop in cycle n: busy=0 and out frozen from n+1. A start in a later cycle resumes from the frozen value with no reload.
- rst asserted mid-count: all outputs take their reset values in the next cycle. A pending tc is cancelled.
- mode changed during RUN takes effect at the next out==1 evaluation.

## Test plan
- Reset then idle: rst=1 for 2 cycles, then drive start with period 0 → out=0, busy=0, tc=0 throughout; start is ignored.
- One-shot: load data=5, then start, mode=0 → out 5,4,3,2,1 with busy=1, then out=0, tc=1, busy=0 for one cycle; out stays 0 and tc=0 afterwards.
- Periodic: load data=3, start, mode=1 for 12 cycles → out cycles 3,2,1,0 repeatedly; tc high only on each out=0 (every 4 cycles).
- Pause/resume: load 10, start, stop when out=6 → out holds at 6 with busy=0 for 5 cycles. Then start → 6,5,… continues with no reload.
- Simultaneous events: start+stop in IDLE with out=4 → stays IDLE. load data=7 + start in the same cycle → RUN with out=7. load data=2 during RUN at out=9 → out=2, then 1, then 0 with tc=1.
- Reset mid-operation: periodic run with period 200, rst at out=1 → next cycle out=0, tc=0, busy=0, period_reg=0. A subsequent start is ignored.
